// File: rtl/video_timing_pkg.sv
// Shared timing defaults, counter widths and the per-axis phase encoding
// used by the horizontal and vertical timing axes.
package video_timing_pkg;

    localparam int H_ACT_DEF  = 1024;
    localparam int H_FP_DEF   = 24;
    localparam int H_SYNC_DEF = 136;
    localparam int H_BP_DEF   = 160;
    localparam int V_ACT_DEF  = 768;
    localparam int V_FP_DEF   = 3;
    localparam int V_SYNC_DEF = 6;
    localparam int V_BP_DEF   = 29;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;
    localparam int POS_W   = 12;

    // Both axes share one encoding: H_ACTV/V_ACTV map to PH_ACTV, and so on.
    typedef enum logic [1:0] {
        PH_ACTV = 2'd0,
        PH_FPOR = 2'd1,
        PH_SYNC = 2'd2,
        PH_BPOR = 2'd3
    } phase_e;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int H_TOT_DEF = axis_total(H_ACT_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOT_DEF = axis_total(V_ACT_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/video_timing_gen_timing_axis.sv
// One timing axis: a wrapping position counter plus the four-phase
// active/front-porch/sync/back-porch FSM, stepped by adv.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int W    = 11,
    parameter int ACT  = H_ACT_DEF,
    parameter int FP   = H_FP_DEF,
    parameter int SYNC = H_SYNC_DEF,
    parameter int BP   = H_BP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output phase_e       phase
);

    localparam int TOT = axis_total(ACT, FP, SYNC, BP);
    localparam logic [W-1:0] ACT_END  = W'(ACT - 1);
    localparam logic [W-1:0] FP_END   = W'(ACT + FP - 1);
    localparam logic [W-1:0] SYNC_END = W'(ACT + FP + SYNC - 1);
    localparam logic [W-1:0] LAST     = W'(TOT - 1);

    logic [W-1:0] cnt_nxt;
    phase_e       phase_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= PH_ACTV;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
        end
    end

    // Phase steps on the last count of each region so it always matches cnt.
    always_comb begin
        cnt_nxt   = cnt;
        phase_nxt = phase;
        if (adv) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
            unique case (phase)
                PH_ACTV: if (cnt == ACT_END)  phase_nxt = PH_FPOR;
                PH_FPOR: if (cnt == FP_END)   phase_nxt = PH_SYNC;
                PH_SYNC: if (cnt == SYNC_END) phase_nxt = PH_BPOR;
                PH_BPOR: if (cnt == LAST)     phase_nxt = PH_ACTV;
            endcase
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal and vertical timing axes feeding a
// registered output stage (syncs, active flags, position, frame start).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACT  = H_ACT_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic             o_sync_vs,
    output logic             o_sync_hs,
    output logic             o_sync_va,
    output logic             o_sync_ha,
    output logic             o_sync_de,
    output logic [POS_W-1:0] o_pos_x,
    output logic [POS_W-1:0] o_pos_y,
    output logic             o_frame_start,
    output phase_e           o_dbg_h_phase,
    output phase_e           o_dbg_v_phase
);

    localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(axis_total(H_ACT, H_FP, H_SYNC, H_BP) - 1);

    logic [H_CNT_W-1:0] hcnt;
    logic [V_CNT_W-1:0] vcnt;
    phase_e             h_phase;
    phase_e             v_phase;
    logic               h_wrap;
    logic               h_act;
    logic               v_act;
    logic               de_nxt;

    // The vertical axis steps exactly on the enabled cycle where hcnt wraps.
    assign h_wrap = i_en && (hcnt == H_LAST);

    timing_axis #(.W(H_CNT_W), .ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .adv   (i_en),
        .cnt   (hcnt),
        .phase (h_phase)
    );

    timing_axis #(.W(V_CNT_W), .ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .adv   (h_wrap),
        .cnt   (vcnt),
        .phase (v_phase)
    );

    assign h_act  = (h_phase == PH_ACTV);
    assign v_act  = (v_phase == PH_ACTV);
    assign de_nxt = h_act && v_act;

    assign o_dbg_h_phase = h_phase;
    assign o_dbg_v_phase = v_phase;

    // Outputs decode the counter state present before the edge: one clock of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sync_hs     <= ~HS_POL;
            o_sync_vs     <= ~VS_POL;
            o_sync_ha     <= 1'b0;
            o_sync_va     <= 1'b0;
            o_sync_de     <= 1'b0;
            o_pos_x       <= '0;
            o_pos_y       <= '0;
            o_frame_start <= 1'b0;
        end else if (i_en) begin
            o_sync_hs     <= (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            o_sync_vs     <= (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            o_sync_ha     <= h_act;
            o_sync_va     <= v_act;
            o_sync_de     <= de_nxt;
            o_pos_x       <= de_nxt ? POS_W'(hcnt) : '0;
            o_pos_y       <= de_nxt ? POS_W'(vcnt) : '0;
            o_frame_start <= de_nxt && (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default-timing instance for line/enable checks, plus two
// reduced-timing instances (normal and inverted sync polarity) for frame checks.
module tb_video_timing_gen;

    logic clk;
    logic rst;
    logic en;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // Default-timing instance
    logic        f_vs, f_hs, f_va, f_ha, f_de, f_fs;
    logic [11:0] f_x, f_y;
    logic [1:0]  f_hph, f_vph;

    // Reduced timing: H 8/2/3/3 (16), V 4/1/2/2 (9), frame 144 clocks
    logic        s_vs, s_hs, s_va, s_ha, s_de, s_fs;
    logic [11:0] s_x, s_y;
    logic [1:0]  s_hph, s_vph;

    logic        i_vs, i_hs, i_va, i_ha, i_de, i_fs;
    logic [11:0] i_x, i_y;
    logic [1:0]  i_hph, i_vph;

    video_timing_gen u_full (
        .clk(clk), .rst(rst), .i_en(en),
        .o_sync_vs(f_vs), .o_sync_hs(f_hs), .o_sync_va(f_va), .o_sync_ha(f_ha),
        .o_sync_de(f_de), .o_pos_x(f_x), .o_pos_y(f_y), .o_frame_start(f_fs),
        .o_dbg_h_phase(f_hph), .o_dbg_v_phase(f_vph)
    );

    video_timing_gen #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk(clk), .rst(rst), .i_en(en),
        .o_sync_vs(s_vs), .o_sync_hs(s_hs), .o_sync_va(s_va), .o_sync_ha(s_ha),
        .o_sync_de(s_de), .o_pos_x(s_x), .o_pos_y(s_y), .o_frame_start(s_fs),
        .o_dbg_h_phase(s_hph), .o_dbg_v_phase(s_vph)
    );

    video_timing_gen #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_inv (
        .clk(clk), .rst(rst), .i_en(en),
        .o_sync_vs(i_vs), .o_sync_hs(i_hs), .o_sync_va(i_va), .o_sync_ha(i_ha),
        .o_sync_de(i_de), .o_pos_x(i_x), .o_pos_y(i_y), .o_frame_start(i_fs),
        .o_dbg_h_phase(i_hph), .o_dbg_v_phase(i_vph)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int ha_cnt, hs_low, hs_fall0, hs_fall1, n_fall, fs_cnt, x700, x1100;
        int de_cnt, va_cnt, vs_low, vs_fall, fs_n, fs_idx1, px, py, de64, inv_bad, frz_bad;
        logic p_hs, p_vs;
        logic [11:0] snap_x, snap_y;
        logic [5:0]  snap_o;

        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        step();

        // Reset state
        check("rst_de", f_de, 0);
        check("rst_ha_va", {f_ha, f_va}, 0);
        check("rst_pos", {f_x, f_y}, 0);
        check("rst_fs", f_fs, 0);
        check("rst_hs_vs", {f_hs, f_vs}, 2'b11);
        check("rst_inv_hs_vs", {i_hs, i_vs}, 2'b00);
        check("rst_phase", {f_hph, f_vph}, 0);

        // First enabled cycle after release shows pixel (0,0)
        rst = 1'b0;
        step();
        check("first_de", f_de, 1);
        check("first_pos", {f_x, f_y}, 0);
        check("first_fs", f_fs, 1);
        check("first_hs_vs", {f_hs, f_vs}, 2'b11);

        // Two full lines on the default timing; sample k shows hcnt = k mod 1344
        ha_cnt = 0; hs_low = 0; hs_fall0 = -1; hs_fall1 = -1; n_fall = 0;
        fs_cnt = 0; x700 = -1; x1100 = -1; p_hs = 1'b1;
        for (int k = 0; k < 2688; k++) begin
            if (k < 1344 && f_ha) ha_cnt++;
            if (k < 1344 && !f_hs) hs_low++;
            if (p_hs && !f_hs) begin
                if (n_fall == 0) hs_fall0 = k;
                if (n_fall == 1) hs_fall1 = k;
                n_fall++;
            end
            p_hs = f_hs;
            if (k > 0 && f_fs) fs_cnt++;
            if (k == 700) x700 = int'(f_x);
            if (k == 1100) x1100 = int'(f_x);
            step();
        end
        check("line_ha_count", ha_cnt, 1024);
        check("line_hs_low_count", hs_low, 136);
        check("line_hs_start", hs_fall0, 1048);
        check("line_hs_period", hs_fall1 - hs_fall0, 1344);
        check("line_pos_x_700", x700, 700);
        check("line_blank_pos_x", x1100, 0);
        check("line_no_extra_fs", fs_cnt, 0);
        check("line2_start", {f_de, f_x, f_y}, {1'b1, 12'd0, 12'd2});

        // Freeze at hcnt=500 for 10 cycles, then resume
        do_reset();
        repeat (500) step();
        check("pre_freeze_x", f_x, 500);
        snap_x = f_x;
        snap_y = f_y;
        snap_o = {f_hs, f_vs, f_ha, f_va, f_de, f_fs};
        en = 1'b0;
        frz_bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (f_x !== snap_x || f_y !== snap_y || {f_hs, f_vs, f_ha, f_va, f_de, f_fs} !== snap_o)
                frz_bad++;
        end
        check("freeze_hold", frz_bad, 0);
        en = 1'b1;
        for (int k = 501; k < 506; k++) exp_q.push_back(32'(k));
        while (exp_q.size() > 0) begin
            step();
            check("resume_pos_x", f_x, exp_q.pop_front());
        end

        // Two frames on reduced timing, with the inverted-polarity twin compared alongside
        do_reset();
        de_cnt = 0; va_cnt = 0; vs_low = 0; vs_fall = -1; fs_n = 0; fs_idx1 = -1;
        px = -1; py = -1; de64 = -1; inv_bad = 0; p_vs = 1'b1;
        for (int k = 0; k < 288; k++) begin
            if (k < 144) begin
                if (s_de) de_cnt++;
                if (s_va) va_cnt++;
                if (!s_vs) vs_low++;
                if (p_vs && !s_vs && vs_fall < 0) vs_fall = k;
            end
            p_vs = s_vs;
            if (s_fs) begin
                if (fs_n == 1) fs_idx1 = k;
                fs_n++;
            end
            if (k == 55) begin
                px = int'(s_x);
                py = int'(s_y);
            end
            if (k == 64) de64 = int'({s_de, s_x, s_y});
            if (i_hs !== ~s_hs || i_vs !== ~s_vs || i_ha !== s_ha || i_va !== s_va ||
                i_de !== s_de || i_fs !== s_fs || i_x !== s_x || i_y !== s_y)
                inv_bad++;
            step();
        end
        check("frame_de_count", de_cnt, 32);
        check("frame_va_count", va_cnt, 64);
        check("frame_vs_low_count", vs_low, 32);
        check("frame_vs_start", vs_fall, 80);
        check("frame_fs_count", fs_n, 2);
        check("frame_fs_period", fs_idx1, 144);
        check("frame_pos_7_3", {px[11:0], py[11:0]}, {12'd7, 12'd3});
        check("frame_blank_line4", de64, 0);
        check("pol_inverted_match", inv_bad, 0);

        // Reset during vertical sync aborts the frame cleanly
        do_reset();
        repeat (83) step();
        check("mid_vs_low", s_vs, 0);
        rst = 1'b1;
        step();
        check("mid_rst_state", {s_vs, s_hs, s_de, s_fs}, 4'b1100);
        rst = 1'b0;
        step();
        check("mid_release_fs", s_fs, 1);
        check("mid_release_pix", {s_de, s_vs, s_x, s_y}, {1'b1, 1'b1, 24'd0});
        check("mid_release_full_fs", f_fs, 1);
        step();
        check("mid_fs_one_cycle", s_fs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
